sa_tile_engine: RTL

- Parametrised ROWS x COLS output-stationary systolic matmul tile: C[ROWS][COLS] = sum over k of A[:,k] * B[k,:].
- Generational step over the fixed 2x2 free-running array: internal input skewing, ready/valid operand streaming with stall, a start/busy/done sequencing FSM with automatic drain, optional saturating accumulation, and streamed row-by-row result readout.
- Sits between the operand buffers and the result writeback path.

---
 rtl/sa_tile_engine.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sa_tile_engine.sv
// Output-stationary ROWS x COLS systolic matmul tile with skewed operand injection,
// ready/valid beat streaming, automatic drain and row-by-row result readout.
module sa_tile_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC   = 32,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned KW    = 16,
    parameter int unsigned SAT   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*ROWS-1:0]   a_col,
    input  logic [WIDTH*COLS-1:0]   b_row,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC*COLS-1:0]     out_row,
    output logic                    out_last,
    output logic                    done
);

    localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DW        = $clog2(ROWS + COLS);
    localparam int unsigned DRAIN_LEN = ROWS + COLS - 2;
    localparam int unsigned PW        = 2 * WIDTH;
    localparam int unsigned AW1       = ACC + 1;
    localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
    localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_e;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_len_q, k_len_d;
    logic [KW-1:0]         beat_q, beat_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  done_q, done_d;
    logic [ACC*COLS-1:0]   out_row_q, out_row_d;

    logic                  clr;
    logic                  adv;
    logic [RW-1:0]         rd_sel;
    logic [ACC*COLS-1:0]   row_pack;

    logic signed [WIDTH-1:0] a_inj [ROWS];
    logic signed [WIDTH-1:0] b_inj [COLS];
    logic signed [WIDTH-1:0] a_op  [ROWS][COLS];
    logic signed [WIDTH-1:0] b_op  [ROWS][COLS];
    logic signed [ACC-1:0]   acc_all [ROWS][COLS];

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign out_row   = out_row_q;

    // Operands enter only on accepted LOAD beats; DRAIN pushes zeros through the array.
    always_comb begin
        for (int i = 0; i < int'(ROWS); i++) begin
            a_inj[i] = (state_q == S_LOAD) ? a_col[i*WIDTH +: WIDTH] : '0;
        end
        for (int j = 0; j < int'(COLS); j++) begin
            b_inj[j] = (state_q == S_LOAD) ? b_row[j*WIDTH +: WIDTH] : '0;
        end
    end

    for (genvar i = 0; i < int'(ROWS); i++) begin : g_askew
        if (i == 0) begin : g_direct
            assign a_op[0][0] = a_inj[0];
        end else begin : g_chain
            logic signed [WIDTH-1:0] sr_q [i];
            logic signed [WIDTH-1:0] sr_d [i];
            always_comb begin
                sr_d = sr_q;
                if (clr) begin
                    for (int s = 0; s < i; s++) sr_d[s] = '0;
                end else if (adv) begin
                    sr_d[0] = a_inj[i];
                    for (int s = 1; s < i; s++) sr_d[s] = sr_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign a_op[i][0] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < int'(COLS); j++) begin : g_bskew
        if (j == 0) begin : g_direct
            assign b_op[0][0] = b_inj[0];
        end else begin : g_chain
            logic signed [WIDTH-1:0] sr_q [j];
            logic signed [WIDTH-1:0] sr_d [j];
            always_comb begin
                sr_d = sr_q;
                if (clr) begin
                    for (int s = 0; s < j; s++) sr_d[s] = '0;
                end else if (adv) begin
                    sr_d[0] = b_inj[j];
                    for (int s = 1; s < j; s++) sr_d[s] = sr_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign b_op[0][j] = sr_q[j-1];
        end
    end

    // PE grid: A moves right, B moves down, accumulator stays in place.
    for (genvar i = 0; i < int'(ROWS); i++) begin : g_row
        for (genvar j = 0; j < int'(COLS); j++) begin : g_col
            logic signed [PW-1:0]  prod;
            logic signed [ACC-1:0] prod_x;
            logic signed [ACC:0]   sum;
            logic signed [ACC-1:0] acc_n, acc_q, acc_d;

            always_comb begin
                prod   = PW'(a_op[i][j]) * PW'(b_op[i][j]);
                prod_x = ACC'(prod);
                sum    = AW1'(acc_q) + AW1'(prod_x);
                acc_n  = sum[ACC-1:0];
                if ((SAT != 0) && (sum[ACC] != sum[ACC-1])) begin
                    acc_n = sum[ACC] ? ACC_MIN : ACC_MAX;
                end
                acc_d = acc_q;
                if (clr) begin
                    acc_d = '0;
                end else if (adv) begin
                    acc_d = acc_n;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else        acc_q <= acc_d;
            end
            assign acc_all[i][j] = acc_q;

            if (j < int'(COLS) - 1) begin : g_apass
                logic signed [WIDTH-1:0] a_q, a_d;
                always_comb begin
                    a_d = a_q;
                    if (clr)      a_d = '0;
                    else if (adv) a_d = a_op[i][j];
                end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_q <= '0;
                    else        a_q <= a_d;
                end
                assign a_op[i][j+1] = a_q;
            end

            if (i < int'(ROWS) - 1) begin : g_bpass
                logic signed [WIDTH-1:0] b_q, b_d;
                always_comb begin
                    b_d = b_q;
                    if (clr)      b_d = '0;
                    else if (adv) b_d = b_op[i][j];
                end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_q <= '0;
                    else        b_q <= b_d;
                end
                assign b_op[i+1][j] = b_q;
            end
        end
    end

    // Row to present next: row 0 on entry to OUT, otherwise the one after the current.
    always_comb begin
        rd_sel = '0;
        if (out_valid_q && (row_q != RW'(ROWS - 1))) begin
            rd_sel = row_q + RW'(1);
        end
        row_pack = '0;
        for (int j = 0; j < int'(COLS); j++) begin
            row_pack[j*ACC +: ACC] = acc_all[rd_sel][j];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;
        done_d      = 1'b0;
        clr         = 1'b0;
        adv         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    k_len_d = k_len;
                    beat_d  = '0;
                    drain_d = '0;
                    row_d   = '0;
                    state_d = (k_len == '0) ? S_OUT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    adv    = 1'b1;
                    beat_d = beat_q + KW'(1);
                    if (beat_q + KW'(1) == k_len_q) begin
                        state_d = (DRAIN_LEN == 0) ? S_OUT : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                adv     = 1'b1;
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(DRAIN_LEN - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_row_d   = row_pack;
                    out_last_d  = (rd_sel == RW'(ROWS - 1));
                end else if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        row_d      = rd_sel;
                        out_row_d  = row_pack;
                        out_last_d = (rd_sel == RW'(ROWS - 1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_q      <= '0;
            drain_q     <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            row_q       <= row_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            out_row_q   <= out_row_d;
        end
    end

endmodule
